// File: rtl/oerv_dbus_wr.sv
// oerv_dbus_wr: collects the rs2 store operand as four 8-bit beats (LSB first),
// replicates it across byte lanes according to the access size, derives the
// byte selects from size and address offset, and runs one data-bus write.
// Optional build macro: OERV_MISALIGN_TRAP_EN -- when defined, misaligned half
// and word stores are rejected with a one-cycle o_misalign pulse instead of
// being issued on the bus.
module oerv_dbus_wr (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_st_en,
    input  logic        i_cnt_en,
    input  logic [7:0]  i_dat,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lsb,
    output logic        o_busy,
    output logic        o_dbus_cyc,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_dat,
    output logic [3:0]  o_dbus_sel,
    input  logic        i_dbus_ack,
    output logic        o_done,
    output logic        o_misalign
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REQ     = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [31:0] dat_q;
    logic [31:0] word_nxt;
    logic        beat_acc;
    logic        last_beat;
    logic        misalign;
    logic        issue;
    logic        ack_req;

    // Place the assembled word on the byte lanes the access size can hit.
    function automatic logic [31:0] lane_replicate(input logic [31:0] w,
                                                   input logic [1:0]  size);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte enables from access size and address offset; a half only looks at
    // lsb[1], a word ignores the offset entirely.
    function automatic logic [3:0] byte_select(input logic [1:0] size,
                                               input logic [1:0] lsb);
        logic [3:0] r;
        case (size)
            2'b00:   r = 4'b0001 << lsb;
            2'b01:   r = lsb[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Beats are only taken while not busy on the bus; REQ ignores i_cnt_en.
    assign beat_acc  = i_cnt_en && i_st_en && (state_q != REQ);
    assign last_beat = beat_acc && (cnt_q == 2'd3);
    assign word_nxt  = {i_dat, dat_q[31:8]};
    assign ack_req   = (state_q == REQ) && i_dbus_ack;

`ifdef OERV_MISALIGN_TRAP_EN
    assign misalign = ((i_size == 2'b01) && i_lsb[0]) ||
                      (i_size[1] && (i_lsb != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign issue     = last_beat && !misalign;
    assign o_busy    = (state_q != IDLE);
    assign o_dbus_we = 1'b1;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: collect four beats, then either request or drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (last_beat) begin
                    state_d = misalign ? IDLE : REQ;
                end
            end
            REQ: begin
                if (i_dbus_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat counter and shift register assembling the store word LSB first.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= 2'd0;
            dat_q <= 32'd0;
        end else if (beat_acc) begin
            cnt_q <= cnt_q + 2'd1;
            dat_q <= word_nxt;
        end
    end

    // Bus request: data and selects latched at the 4th beat, held until ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_dbus_cyc <= 1'b0;
            o_dbus_dat <= 32'd0;
            o_dbus_sel <= 4'd0;
            o_done     <= 1'b0;
        end else begin
            o_done <= ack_req;
            if (issue) begin
                o_dbus_cyc <= 1'b1;
                o_dbus_dat <= lane_replicate(word_nxt, i_size);
                o_dbus_sel <= byte_select(i_size, i_lsb);
            end else if (ack_req) begin
                o_dbus_cyc <= 1'b0;
            end
        end
    end

`ifdef OERV_MISALIGN_TRAP_EN
    // One-cycle pulse for a store rejected at its 4th beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_misalign <= 1'b0;
        end else begin
            o_misalign <= last_beat && misalign;
        end
    end
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_oerv_dbus_wr.sv
// Directed bench for oerv_dbus_wr with a scoreboard of expected bus writes.
module tb_oerv_dbus_wr;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_st_en;
    logic        i_cnt_en;
    logic [7:0]  i_dat;
    logic [1:0]  i_size;
    logic [1:0]  i_lsb;
    logic        o_busy;
    logic        o_dbus_cyc;
    logic        o_dbus_we;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        i_dbus_ack;
    logic        o_done;
    logic        o_misalign;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  sel;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    oerv_dbus_wr dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_st_en    (i_st_en),
        .i_cnt_en   (i_cnt_en),
        .i_dat      (i_dat),
        .i_size     (i_size),
        .i_lsb      (i_lsb),
        .o_busy     (o_busy),
        .o_dbus_cyc (o_dbus_cyc),
        .o_dbus_we  (o_dbus_we),
        .o_dbus_dat (o_dbus_dat),
        .o_dbus_sel (o_dbus_sel),
        .i_dbus_ack (i_dbus_ack),
        .o_done     (o_done),
        .o_misalign (o_misalign)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
`ifdef OERV_MISALIGN_TRAP_EN
        return ((size == 2'b01) && lsb[0]) || (size[1] && (lsb != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [1:0] size, input logic [1:0] lsb);
        exp_t e;
        if (size == 2'b00) begin
            e.dat = {w[7:0], w[7:0], w[7:0], w[7:0]};
            e.sel = (lsb == 2'd0) ? 4'b0001 : (lsb == 2'd1) ? 4'b0010 :
                    (lsb == 2'd2) ? 4'b0100 : 4'b1000;
        end else if (size == 2'b01) begin
            e.dat = {w[15:0], w[15:0]};
            e.sel = lsb[1] ? 4'b1100 : 4'b0011;
        end else begin
            e.dat = w;
            e.sel = 4'b1111;
        end
        return e;
    endfunction

    // Drives four beats (with gap idle cycles after each) and checks the
    // request appears exactly one cycle after the 4th beat; returns in the
    // first REQ cycle with the popped expectation in e.
    task automatic send_store(input string tag, input logic [31:0] w,
                              input logic [1:0] size, input logic [1:0] lsb,
                              input int gap, output exp_t e, output logic issued);
        issued = !is_misaligned(size, lsb);
        if (issued) sb.push_back(model(w, size, lsb));
        e = '0;
        i_size = size;
        i_lsb  = lsb;
        for (int b = 0; b < 4; b++) begin
            i_st_en  = 1'b1;
            i_cnt_en = 1'b1;
            i_dat    = w[8*b +: 8];
            step();
            i_cnt_en = 1'b0;
            i_dat    = 8'h00;
            if (b == 0) begin
                check({tag, "_busy_first"}, o_busy, 1'b1);
                check({tag, "_done_first"}, o_done, 1'b0);
            end
            if (b < 3) begin
                check({tag, "_cyc_early"}, o_dbus_cyc, 1'b0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    check({tag, "_cyc_gap"}, o_dbus_cyc, 1'b0);
                end
            end
        end
        i_st_en = 1'b0;
        if (issued) begin
            check({tag, "_cyc"}, o_dbus_cyc, 1'b1);
            check({tag, "_mis"}, o_misalign, 1'b0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb: observed=empty expected=entry", tag);
            end else begin
                e = sb.pop_front();
                check({tag, "_dat"}, o_dbus_dat, e.dat);
                check({tag, "_sel"}, {28'd0, o_dbus_sel}, {28'd0, e.sel});
            end
        end else begin
            check({tag, "_cyc_none"}, o_dbus_cyc, 1'b0);
            check({tag, "_mis_pulse"}, o_misalign, 1'b1);
            step();
            check({tag, "_mis_end"}, o_misalign, 1'b0);
            check({tag, "_cyc_none2"}, o_dbus_cyc, 1'b0);
            check({tag, "_busy_none"}, o_busy, 1'b0);
        end
    endtask

    // Holds the request for hold cycles in total (beats offered meanwhile
    // must be ignored), acks, and returns in the o_done cycle.
    task automatic do_req(input string tag, input exp_t e, input int hold);
        i_st_en  = 1'b1;
        i_cnt_en = 1'b1;
        i_dat    = 8'hFF;
        for (int i = 1; i < hold; i++) begin
            step();
            check({tag, "_cyc_hold"}, o_dbus_cyc, 1'b1);
            check({tag, "_dat_hold"}, o_dbus_dat, e.dat);
            check({tag, "_sel_hold"}, {28'd0, o_dbus_sel}, {28'd0, e.sel});
            check({tag, "_done_hold"}, o_done, 1'b0);
        end
        i_dbus_ack = 1'b1;
        step();
        i_dbus_ack = 1'b0;
        i_cnt_en   = 1'b0;
        i_st_en    = 1'b0;
        i_dat      = 8'h00;
        check({tag, "_cyc_off"}, o_dbus_cyc, 1'b0);
        check({tag, "_done"}, o_done, 1'b1);
        check({tag, "_busy_off"}, o_busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        logic issued;

        i_rst_n    = 1'b0;
        i_st_en    = 1'b0;
        i_cnt_en   = 1'b0;
        i_dat      = 8'h00;
        i_size     = 2'b00;
        i_lsb      = 2'b00;
        i_dbus_ack = 1'b0;
        step();
        step();
        check("rst_cyc", o_dbus_cyc, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_mis", o_misalign, 1'b0);
        check("rst_we", o_dbus_we, 1'b1);
        check("rst_dat", o_dbus_dat, 32'h0);
        check("rst_sel", {28'd0, o_dbus_sel}, 32'h0);
        check("rst_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        step();

        // Word store, ack three cycles after cyc rises.
        send_store("word", 32'h12345678, 2'b10, 2'b00, 0, e, issued);
        do_req("word", e, 3);
        // Back-to-back byte store begins in the o_done cycle.
        send_store("byte", 32'h000000AB, 2'b00, 2'b10, 0, e, issued);
        check("byte_exp_dat", o_dbus_dat, 32'hABABABAB);
        check("byte_exp_sel", {28'd0, o_dbus_sel}, 32'h4);
        do_req("byte", e, 1);
        step();
        check("idle_done_end", o_done, 1'b0);

        // Half store with two idle cycles between beats.
        send_store("half", 32'h0000EFCD, 2'b01, 2'b10, 2, e, issued);
        check("half_exp_dat", o_dbus_dat, 32'hEFCDEFCD);
        check("half_exp_sel", {28'd0, o_dbus_sel}, 32'hC);
        do_req("half", e, 2);

        // Beats without i_st_en and an ack in IDLE must have no effect.
        i_st_en  = 1'b0;
        i_cnt_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            i_dat = 8'h5A;
            step();
            check("ign_cyc", o_dbus_cyc, 1'b0);
            check("ign_busy", o_busy, 1'b0);
        end
        i_cnt_en   = 1'b0;
        i_dbus_ack = 1'b1;
        step();
        i_dbus_ack = 1'b0;
        check("ign_ack_done", o_done, 1'b0);
        check("ign_ack_cyc", o_dbus_cyc, 1'b0);
        step();
        check("ign_ack_done2", o_done, 1'b0);

        // Size 11 behaves as a word with offset ignored.
        send_store("sz11", 32'hA5C3E10F, 2'b11, 2'b00, 0, e, issued);
        do_req("sz11", e, 1);

        // Misaligned half at offset 1.
        send_store("mish", 32'h00002211, 2'b01, 2'b01, 1, e, issued);
        if (issued) begin
            check("mish_exp_sel", {28'd0, o_dbus_sel}, 32'h3);
            check("mish_exp_dat", o_dbus_dat, 32'h22112211);
            do_req("mish", e, 2);
        end
        step();

        // Reset while the request is outstanding abandons it.
        send_store("rstq", 32'hCAFEF00D, 2'b10, 2'b00, 0, e, issued);
        i_rst_n = 1'b0;
        step();
        check("rstq_cyc", o_dbus_cyc, 1'b0);
        check("rstq_done", o_done, 1'b0);
        check("rstq_busy", o_busy, 1'b0);
        check("rstq_dat", o_dbus_dat, 32'h0);
        check("rstq_sel", {28'd0, o_dbus_sel}, 32'h0);
        i_rst_n = 1'b1;
        step();
        check("rstq_done2", o_done, 1'b0);
        check("rstq_cyc2", o_dbus_cyc, 1'b0);

        send_store("dead", 32'hDEADBEEF, 2'b10, 2'b00, 0, e, issued);
        do_req("dead", e, 1);
        step();
        check("dead_done_end", o_done, 1'b0);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oerv_dbus_wr.md
# oerv_dbus_wr

Store-data collector and data-bus write initiator for the 8-bit-per-cycle oerv core. Accepts the rs2 store operand as four 8-bit beats, LSB byte first, from the serial datapath. Assembles the beats into a 32-bit word, applies byte-lane replication and byte selects from the access size and address offset, and runs one write cycle on the data bus. It is the parallelising end of the serial operand path, the counterpart to the instruction-word-to-serial-immediate unpacking in the decoder.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  core clock; all state updates on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_st_en  in  1  current instruction is a store; qualifies beats
- i_cnt_en  in  1  one 8-bit beat valid on i_dat this cycle
- i_dat  in  8  store data beat; beat 0 = bits 7:0, beat 3 = bits 31:24
- i_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- i_lsb  in  2  address bits 1:0
- o_busy  out  1  state is not IDLE
- o_dbus_cyc  out  1  write request active
- o_dbus_we  out  1  constant 1
- o_dbus_dat  out  32  write data
- o_dbus_sel  out  4  byte enables
- i_dbus_ack  in  1  responder accepted the write
- o_done  out  1  one-cycle pulse after ack
- o_misalign  out  1  one-cycle pulse on a rejected misaligned store (macro only)

## Operation
- States: IDLE, COLLECT, REQ.
- A beat is accepted when i_cnt_en and i_st_en are both high and the state is IDLE or COLLECT. Accepted beats shift into a 32-bit register: dat <= {i_dat, dat[31:8]}. A 2-bit beat counter increments per accepted beat.
- IDLE -> COLLECT on the first accepted beat.
- COLLECT holds through cycles with no accepted beat; gaps are legal.
- On the 4th accepted beat:
  - i_size and i_lsb are sampled.
  - o_dbus_dat and o_dbus_sel are registered.
  - The counter wraps to 0.
  - The state goes to REQ.
- Data replication:
  - byte: {4{dat[7:0]}}
  - half: {2{dat[15:0]}}
  - word: dat
- Selects:
  - byte: 1 << lsb
  - half: lsb[1] ? 1100 : 0011
  - word: 1111
- REQ: o_dbus_cyc high. o_dbus_dat and o_dbus_sel stay stable until ack. i_cnt_en is ignored.
- REQ -> IDLE on i_dbus_ack; o_done is registered high for the following cycle.
- i_dbus_ack is ignored outside REQ.
- Reset (i_rst_n low at an edge), from any state:
  - state IDLE, counter 0
  - o_dbus_cyc, o_done, o_misalign 0
  - o_dbus_dat 0, o_dbus_sel 0
  - a pending write is abandoned; no o_done is produced for it

## Timing
- 4th beat accepted at edge N: o_dbus_cyc is high from N+1.
- Ack sampled at edge M: o_dbus_cyc is low and o_done is high from M+1, for exactly one cycle.
- Minimum request length is one cycle (ack in the first REQ cycle).
- Back-to-back stores: beats are accepted in the o_done cycle, because the state is already IDLE.
- o_busy is combinational from state. It is high from the cycle after the first accepted beat until the cycle after ack.
- Reset values of all outputs are 0, except o_dbus_we, which is 1.

## Configuration
- OERV_MISALIGN_TRAP_EN defined: at the 4th beat, the store is misaligned if it is a half with lsb[0]=1 or a word with lsb!=00. A misaligned store:
  - does not enter REQ; the state goes to IDLE
  - pulses o_misalign for one cycle at N+1
  - never asserts o_dbus_cyc
- Not defined:
  - o_misalign is tied 0.
  - Half uses lsb[1] only; word ignores lsb.
  - Every store is issued.

## Test plan
- Word store: beats 78,56,34,12, size=10, lsb=00, ack 3 cycles after cyc rises -> dat 0x12345678, sel 1111; cyc held 3 cycles; o_done for 1 cycle after ack.
- Byte store: beats AB,00,00,00, size=00, lsb=10 -> dat 0xABABABAB, sel 0100.
- Half store with gaps: beats CD,EF,00,00 with 2 idle cycles between beats, size=01, lsb=10 -> dat 0xEFCDEFCD, sel 1100; cyc only after the 4th beat.
- Misaligned half, lsb=01:
  - with OERV_MISALIGN_TRAP_EN: no cyc, o_misalign pulses once
  - without it: cyc asserted with sel 0011
- Reset while in REQ before ack -> cyc low next cycle, no o_done. A following word store 0xDEADBEEF completes normally.
- Beats with i_st_en=0 ignored; ack pulse in IDLE ignored -> counter stays 0, no cyc, no o_done.
